// File: rtl/ysyx_25060173_pkg.sv
// Shared definitions for the instruction memory: FSM encoding and the default
// fetch base address.
package ysyx_25060173_pkg;

   localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int unsigned IMEM_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } imem_state_e;

endpackage

// File: rtl/ysyx_25060173_sram_1r1w.sv
// Word-wide storage with a synchronous write port and a combinational read port;
// no reset, so contents survive a reset of the surrounding logic.
module ysyx_25060173_sram_1r1w #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_25060173_imem.sv
// Instruction fetch memory: one outstanding request, fixed LATENCY, fault on
// misaligned or out-of-window addresses, plus a loader write port.
module ysyx_25060173_imem
   import ysyx_25060173_pkg::*;
#(
   parameter logic [31:0] BASE    = IMEM_BASE_DEFAULT,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_inst,
   output logic                     rsp_err,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [31:0]              ld_data,
   output logic [31:0]              fetch_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
   localparam logic [IMEM_CNT_W-1:0] LAT_LOAD = IMEM_CNT_W'(LATENCY - 1);

   imem_state_e           state_q, state_d;
   logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           inst_q, inst_d;
   logic                  err_q, err_d;
   logic [31:0]           fetch_cnt_q, fetch_cnt_d;

   logic [31:0] off;
   logic        fault;
   logic [31:0] rdata;

   // Wrap-around subtraction makes addresses below BASE land far out of range.
   assign off   = addr_q - BASE;
   assign fault = (addr_q[1:0] != 2'b00) || ({1'b0, off} >= SPAN);

   ysyx_25060173_sram_1r1w #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk     (clk),
      .we_i    (ld_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .raddr_i (off[AW+1:2]),
      .rdata_o (rdata)
   );

   assign req_ready = (state_q == ST_IDLE) && reset;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_inst  = inst_q;
   assign rsp_err   = err_q;
   assign fetch_cnt = fetch_cnt_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      inst_d      = inst_q;
      err_d       = err_q;
      fetch_cnt_d = fetch_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               cnt_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               err_d   = fault;
               inst_d  = fault ? '0 : rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               fetch_cnt_d = fetch_cnt_q + 32'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         inst_q      <= '0;
         err_q       <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         inst_q      <= inst_d;
         err_q       <= err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25060173_imem.sv
// Self-checking bench: two instances (LATENCY 1 and 3) sharing clock, reset and
// loader, checked against a word-array model of the memory.
module tb_ysyx_25060173_imem;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          NI    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   logic        req_valid [NI];
   logic        req_ready [NI];
   logic [31:0] req_addr  [NI];
   logic        rsp_valid [NI];
   logic        rsp_ready [NI];
   logic [31:0] rsp_inst  [NI];
   logic        rsp_err   [NI];
   logic [31:0] fetch_cnt [NI];

   logic [31:0] mem_m [DEPTH];
   logic [31:0] cnt_m [NI];
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct {
      int          k;
      logic [31:0] addr;
      int          hold;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   always #5 clk = ~clk;

   ysyx_25060173_imem #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_inst(rsp_inst[0]),
      .rsp_err(rsp_err[0]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .fetch_cnt(fetch_cnt[0])
   );

   ysyx_25060173_imem #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_inst(rsp_inst[1]),
      .rsp_err(rsp_err[1]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .fetch_cnt(fetch_cnt[1])
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic ref_err(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a[1:0] != 2'b00) || (off >= DEPTH * 4);
   endfunction

   function automatic logic [31:0] ref_inst(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return ref_err(a) ? 32'h0 : mem_m[off[11:2]];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load(input logic [9:0] i, input logic [31:0] v);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = i; ld_data = v;
      @(negedge clk);
      ld_we = 1'b0;
      mem_m[i] = v;
   endtask

   // One complete fetch on instance k. noise keeps req_valid high with another
   // address while busy; capw writes wv to the fetched word on the capture edge.
   task automatic fetch(input int k, input logic [31:0] a, input int hold, input bit noise,
                        input bit capw, input logic [31:0] wv,
                        input logic [31:0] e_inst, input logic e_err);
      int          n;
      logic [31:0] off;
      off = a - BASE;
      @(negedge clk);
      chk("req_ready idle", {31'b0, req_ready[k]}, 32'd1);
      req_valid[k] = 1'b1; req_addr[k] = a;
      @(posedge clk);
      @(negedge clk);
      if (noise) req_addr[k] = a ^ 32'h0000_0104;
      else       req_valid[k] = 1'b0;
      n = 0;
      while (!rsp_valid[k] && n < 40) begin
         chk("req_ready busy", {31'b0, req_ready[k]}, 32'd0);
         if (capw && n + 1 == lat_of(k)) begin
            ld_we = 1'b1; ld_addr = off[11:2]; ld_data = wv;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
         ld_we = 1'b0;
      end
      if (capw) mem_m[off[11:2]] = wv;
      chk("latency", 32'(n), 32'(lat_of(k)));
      if (!rsp_valid[k]) begin
         req_valid[k] = 1'b0;
         return;
      end
      chk("rsp_inst", rsp_inst[k], e_inst);
      chk("rsp_err", {31'b0, rsp_err[k]}, {31'b0, e_err});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold valid", {31'b0, rsp_valid[k]}, 32'd1);
         chk("hold inst", rsp_inst[k], e_inst);
         chk("hold err", {31'b0, rsp_err[k]}, {31'b0, e_err});
         chk("hold req_ready", {31'b0, req_ready[k]}, 32'd0);
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      @(posedge clk);
      cnt_m[k] = cnt_m[k] + 32'd1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
      chk("rsp_valid after hs", {31'b0, rsp_valid[k]}, 32'd0);
      chk("req_ready after hs", {31'b0, req_ready[k]}, 32'd1);
      chk("fetch_cnt", fetch_cnt[k], cnt_m[k]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [8];
      logic [31:0] a;
      int          k;

      vecs[0] = '{0, 32'h8000_0000, 0, 32'h0010_0093, 1'b0};
      vecs[1] = '{1, 32'h8000_0004, 5, 32'h0020_8113, 1'b0};
      vecs[2] = '{1, 32'h8000_0002, 0, 32'h0,         1'b1};
      vecs[3] = '{1, 32'h7FFF_FFFC, 1, 32'h0,         1'b1};
      vecs[4] = '{1, 32'h8000_1000, 0, 32'h0,         1'b1};
      vecs[5] = '{0, 32'h8000_0FFC, 2, 32'hFFFF_0001, 1'b0};
      vecs[6] = '{0, 32'hFFFF_FFFC, 0, 32'h0,         1'b1};
      vecs[7] = '{0, 32'h8000_0FFF, 0, 32'h0,         1'b1};

      ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0; cnt_m[i] = '0;
      end
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("reset req_ready", {31'b0, req_ready[i]}, 32'd0);
         chk("reset rsp_valid", {31'b0, rsp_valid[i]}, 32'd0);
         chk("reset rsp_inst", rsp_inst[i], 32'd0);
         chk("reset rsp_err", {31'b0, rsp_err[i]}, 32'd0);
         chk("reset fetch_cnt", fetch_cnt[i], 32'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < int'(DEPTH); i++) load(10'(i), (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000);
      load(10'd0, 32'h0010_0093);
      load(10'd1, 32'h0020_8113);
      load(10'd1023, 32'hFFFF_0001);

      for (int v = 0; v < 8; v++)
         fetch(vecs[v].k, vecs[v].addr, vecs[v].hold, 1'b0, 1'b0, 32'h0, vecs[v].inst, vecs[v].err);

      // Requests presented while busy must be ignored.
      fetch(1, 32'h8000_0008, 2, 1'b1, 1'b0, 32'h0, mem_m[2], 1'b0);
      fetch(0, 32'h8000_0010, 1, 1'b1, 1'b0, 32'h0, mem_m[4], 1'b0);

      // Loader write on the capture edge returns old data; next fetch sees new.
      fetch(0, 32'h8000_0008, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, mem_m[2], 1'b0);
      fetch(0, 32'h8000_0008, 0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
      fetch(1, 32'h8000_000C, 1, 1'b0, 1'b1, 32'hCAFE_F00D, mem_m[3], 1'b0);
      fetch(1, 32'h8000_000C, 0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);

      // Reset while the LATENCY=3 instance is waiting drops the request.
      @(negedge clk);
      req_valid[1] = 1'b1; req_addr[1] = BASE;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      reset = 1'b0;
      #1;
      chk("midreset rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
      chk("midreset req_ready", {31'b0, req_ready[1]}, 32'd0);
      chk("midreset fetch_cnt", fetch_cnt[1], 32'd0);
      cnt_m[0] = '0; cnt_m[1] = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post-reset no rsp", {31'b0, rsp_valid[1]}, 32'd0);
         chk("post-reset req_ready", {31'b0, req_ready[1]}, 32'd1);
      end
      fetch(1, 32'h8000_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0010_0093, 1'b0);
      fetch(0, 32'h8000_0004, 0, 1'b0, 1'b0, 32'h0, 32'h0020_8113, 1'b0);

      // Counter wrap from all-ones.
      @(negedge clk);
      force u_l1.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release u_l1.fetch_cnt_q;
      #1;
      chk("forced fetch_cnt", fetch_cnt[0], 32'hFFFF_FFFF);
      cnt_m[0] = 32'hFFFF_FFFF;
      fetch(0, 32'h8000_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0010_0093, 1'b0);
      chk("fetch_cnt wrap", fetch_cnt[0], 32'h0);

      for (int r = 0; r < 40; r++) begin
         k = int'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0, 1:    a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            2:       a = $urandom;
            default: a = BASE + $urandom_range(0, 4 * DEPTH + 15);
         endcase
         if ($urandom_range(0, 3) == 0) load(10'($urandom_range(0, DEPTH - 1)), $urandom);
         fetch(k, a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'h0,
               ref_inst(a), ref_err(a));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
